// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scan_chain_ctrl
//  Description : Scan chain sequencer. Loads a pattern serially, issues
//                one functional capture cycle, unloads the response into a
//                parallel word and compares it against a latched expected
//                word.
//  Revision    : 1.0  initial release
// ============================================================================
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expected_in,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response,
    output logic                 mismatch
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_CAPTURE   = 3'd2,
        S_SHIFT_OUT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t               state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [CHAIN_LEN-1:0] pattern_q,  pattern_d;
    logic [CHAIN_LEN-1:0] expected_q, expected_d;
    logic [CHAIN_LEN-1:0] response_q, response_d;
    logic                 scan_en_q,  scan_en_d;
    logic                 scan_in_q,  scan_in_d;
    logic                 mismatch_q, mismatch_d;
    logic                 last_shift;

    // The same counter paces both shift phases; it restarts at zero on each
    // phase entry, so the terminal compare also covers CHAIN_LEN=1.
    assign last_shift = (cnt_q == CNT_W'(CHAIN_LEN - 1));

    // Next-state, counter, serial data and response assembly.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pattern_d  = pattern_q;
        expected_d = expected_q;
        response_d = response_q;
        scan_en_d  = scan_en_q;
        scan_in_d  = scan_in_q;
        mismatch_d = mismatch_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pattern_d  = pattern_in;
                    expected_d = expected_in;
                    response_d = '0;
                    mismatch_d = 1'b0;
                    cnt_d      = '0;
                    scan_en_d  = 1'b1;
                    scan_in_d  = pattern_in[0];
                    state_d    = S_SHIFT_IN;
                end
            end

            S_SHIFT_IN: begin
                if (last_shift) begin
                    cnt_d     = '0;
                    scan_en_d = 1'b0;
                    scan_in_d = 1'b0;
                    state_d   = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Present the bit the chain will take at the next edge.
                    for (int i = 1; i < CHAIN_LEN; i++) begin
                        if (cnt_q == CNT_W'(i - 1)) begin
                            scan_in_d = pattern_q[i];
                        end
                    end
                end
            end

            S_CAPTURE: begin
                scan_en_d = 1'b1;
                scan_in_d = 1'b0;
                state_d   = S_SHIFT_OUT;
            end

            S_SHIFT_OUT: begin
                for (int i = 0; i < CHAIN_LEN; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        response_d[i] = scan_out;
                    end
                end
                if (last_shift) begin
                    cnt_d      = '0;
                    scan_en_d  = 1'b0;
                    // Compare the completed word, including the final bit.
                    mismatch_d = (response_d != expected_q);
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                scan_en_d = 1'b0;
                scan_in_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pattern_q  <= '0;
            expected_q <= '0;
            response_q <= '0;
            scan_en_q  <= 1'b0;
            scan_in_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pattern_q  <= pattern_d;
            expected_q <= expected_d;
            response_q <= response_d;
            scan_en_q  <= scan_en_d;
            scan_in_q  <= scan_in_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign scan_en  = scan_en_q;
    assign scan_in  = scan_in_q;
    assign busy     = (state_q == S_SHIFT_IN) || (state_q == S_CAPTURE) ||
                      (state_q == S_SHIFT_OUT);
    assign done     = (state_q == S_DONE);
    assign response = response_q;
    assign mismatch = mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_chain_ctrl
//  Description : Bench for scan_chain_ctrl with an 8-flop scan chain whose
//                functional inputs are the constant 8'hA5.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scan_chain_ctrl;

    localparam int         N         = 8;
    localparam logic [7:0] CAPTURE_D = 8'hA5;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] pattern_in;
    logic [N-1:0] expected_in;
    logic         scan_out;
    logic         scan_en;
    logic         scan_in;
    logic         busy;
    logic         done;
    logic [N-1:0] response;
    logic         mismatch;

    logic [N-1:0] chain_q;

    int vectors  = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    // Model state: m_t = edges since the accepting edge E0, -1 when idle.
    int           m_t    = -1;
    int           e0_cyc = 0;
    logic [N-1:0] m_pat  = '0;
    logic [N-1:0] m_exp  = '0;
    logic [N-1:0] m_resp = '0;
    logic         m_mis  = 1'b0;

    scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pattern_in  (pattern_in),
        .expected_in (expected_in),
        .scan_out    (scan_out),
        .scan_en     (scan_en),
        .scan_in     (scan_in),
        .busy        (busy),
        .done        (done),
        .response    (response),
        .mismatch    (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scan chain: scan_in -> flop0 -> ... -> flop7 -> scan_out.
    always_ff @(posedge clk) begin
        if (scan_en) chain_q <= {chain_q[N-2:0], scan_in};
        else         chain_q <= CAPTURE_D;
    end
    assign scan_out = chain_q[N-1];

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a sequence is a 2N+2 edge window after E0.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_t    = -1;
            m_resp = '0;
            m_mis  = 1'b0;
        end else if (m_t < 0) begin
            if (start) begin
                m_t    = 0;
                e0_cyc = cyc;
                m_pat  = pattern_in;
                m_exp  = expected_in;
                m_resp = '0;
                m_mis  = 1'b0;
            end
        end else begin
            m_t++;
            if (m_t == 2*N+1) begin
                // Unload reads the deepest flop first.
                m_resp = bitrev(CAPTURE_D);
                m_mis  = (m_resp != m_exp);
            end
            if (m_t == 2*N+2) m_t = -1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic e_en, e_in;
            int   t;
            t    = m_t;
            e_en = ((t >= 0) && (t < N)) || ((t > N) && (t <= 2*N));
            e_in = 1'b0;
            if ((t >= 0) && (t < N)) e_in = m_pat[t];
            check("scan_en", scan_en, e_en);
            check("scan_in", scan_in, e_in);
            check("busy", busy, (t >= 0) && (t <= 2*N));
            check("done", done, t == 2*N+1);
            check("mismatch", mismatch, m_mis);
            if ((t <= N+1) || (t == 2*N+1)) check("response", response, m_resp);
            if (t == N) check("chain_loaded", chain_q, bitrev(m_pat));
        end
    end

    task automatic start_seq(input logic [N-1:0] pat, input logic [N-1:0] exp);
        @(negedge clk);
        pattern_in  = pat;
        expected_in = exp;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        pattern_in  = ~pat;
        expected_in = ~exp;
    endtask

    task automatic wait_done(output int at);
        bit seen;
        seen = 0;
        at   = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                at   = cyc;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    initial begin
        int d1;
        reset       = 1'b1;
        start       = 1'b0;
        pattern_in  = '0;
        expected_in = '0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check("rst_scan_en", scan_en, 0);
        check("rst_scan_in", scan_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_response", response, 8'h00);
        check("rst_mismatch", mismatch, 0);
        reset = 1'b0;

        // Load check and full pass.
        start_seq(8'h3C, 8'hA5);
        check("busy_after_e0", busy, 1);
        repeat (N) @(negedge clk);
        check("capture_chain", chain_q, 8'h3C);
        check("capture_scan_en", scan_en, 0);
        wait_done(d1);
        // done is visible after edge E(2N+1) = E17.
        check("pass_latency", d1 - e0_cyc, 17);
        check("pass_response", response, 8'hA5);
        check("pass_mismatch", mismatch, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        // Fail detection, with results held after done.
        start_seq(8'h3C, 8'hA4);
        wait_done(d1);
        check("fail_response", response, 8'hA5);
        check("fail_mismatch", mismatch, 1);
        repeat (5) @(negedge clk);
        check("fail_mismatch_held", mismatch, 1);
        check("fail_response_held", response, 8'hA5);

        // Start pulsed during SHIFT_IN is ignored.
        start_seq(8'h3C, 8'hA5);
        check("next_start_clears_mismatch", mismatch, 0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d1);
        check("ignored_start_latency", d1 - e0_cyc, 17);
        repeat (10) @(negedge clk);
        check("no_second_sequence", busy, 0);

        // Start held high: second sequence begins right after DONE.
        @(negedge clk);
        pattern_in  = 8'h3C;
        expected_in = 8'hA5;
        start       = 1'b1;
        wait_done(d1);
        @(negedge clk);
        check("held_idle_gap", busy, 0);
        @(negedge clk);
        check("held_restart_busy", busy, 1);
        check("held_restart_cycle", e0_cyc, d1 + 2);
        start = 1'b0;
        wait_done(d1);
        check("held_second_response", response, 8'hA5);

        // Reset in the middle of SHIFT_OUT, then a clean sequence.
        start_seq(8'h3C, 8'hA5);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_scan_en", scan_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_response", response, 8'h00);
        check("midrst_mismatch", mismatch, 0);
        reset = 1'b0;
        start_seq(8'h3C, 8'hA5);
        wait_done(d1);
        check("post_rst_response", response, 8'hA5);
        check("post_rst_mismatch", mismatch, 0);

        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
`default_nettype wire
